// File: rtl/am2950_port.sv
// Registered bidirectional bus port: one holding register per direction with
// full/overrun flags, tristate outputs and a shared active-low interrupt.
module am2950_port #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             ld_ab,
  input  logic             ld_ba,
  input  logic             clr_fab,
  input  logic             clr_fba,
  input  logic             oeb_,
  input  logic             oea_,
  input  logic             ie_ab,
  input  logic             ie_ba,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] a_out,
  output logic             fab,
  output logic             fba,
  output logic             ovr_ab,
  output logic             ovr_ba,
  output logic             int_
);

  // Direction 0 is A-to-B (RAB), direction 1 is B-to-A (RBA).
  logic [WIDTH-1:0] dir_in   [2];
  logic [WIDTH-1:0] dir_data [2];
  logic [1:0]       dir_ld;
  logic [1:0]       dir_clr;
  logic [1:0]       dir_full;
  logic [1:0]       dir_ovr;

  assign dir_in[0] = a_in;
  assign dir_in[1] = b_in;
  assign dir_ld    = {ld_ba, ld_ab};
  assign dir_clr   = {clr_fba, clr_fab};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dir
      logic [WIDTH-1:0] data_reg, data_next;
      logic             full_reg, full_next;
      logic             ovr_reg, ovr_next;

      always_comb begin
        data_next = data_reg;
        full_next = full_reg;
        ovr_next  = ovr_reg;
        if (dir_ld[gi]) begin
          if (!full_reg) begin
            data_next = dir_in[gi];
            full_next = 1'b1;
          end else if (dir_clr[gi]) begin
            // Read-and-refill: consumer takes the old word as the new one lands.
            data_next = dir_in[gi];
          end else begin
            ovr_next = 1'b1;
          end
        end else if (dir_clr[gi]) begin
          full_next = 1'b0;
          ovr_next  = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
          data_reg <= '0;
          full_reg <= 1'b0;
          ovr_reg  <= 1'b0;
        end else begin
          data_reg <= data_next;
          full_reg <= full_next;
          ovr_reg  <= ovr_next;
        end
      end

      assign dir_data[gi] = data_reg;
      assign dir_full[gi] = full_reg;
      assign dir_ovr[gi]  = ovr_reg;
    end
  endgenerate

  assign b_out  = oeb_ ? {WIDTH{1'bz}} : dir_data[0];
  assign a_out  = oea_ ? {WIDTH{1'bz}} : dir_data[1];
  assign fab    = dir_full[0];
  assign fba    = dir_full[1];
  assign ovr_ab = dir_ovr[0];
  assign ovr_ba = dir_ovr[1];
  assign int_   = ~((dir_full[0] & ie_ab) | (dir_full[1] & ie_ba));

endmodule

// File: tb/tb_am2950_port.sv
// Self-checking bench for am2950_port: directed scenarios plus a randomized
// run against a per-direction mailbox model. Released buses are pulled (B high, A low).
module tb_am2950_port;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_ = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         ld_ab = 0, ld_ba = 0, clr_fab = 0, clr_fba = 0;
  logic         oeb_ = 1, oea_ = 1, ie_ab = 0, ie_ba = 0;
  tri1  [W-1:0] b_bus;
  tri0  [W-1:0] a_bus;
  logic         fab, fba, ovr_ab, ovr_ba, int_;

  int checks = 0;
  int errors = 0;

  // Mailbox model: index 0 = A-to-B, 1 = B-to-A.
  logic [W-1:0] m_data [2];
  bit           m_full [2];
  bit           m_ovr  [2];

  always #5 clk = ~clk;

  am2950_port #(.WIDTH(W)) dut (
    .clk(clk), .rst_(rst_), .a_in(a_in), .b_in(b_in),
    .ld_ab(ld_ab), .ld_ba(ld_ba), .clr_fab(clr_fab), .clr_fba(clr_fba),
    .oeb_(oeb_), .oea_(oea_), .ie_ab(ie_ab), .ie_ba(ie_ba),
    .b_out(b_bus), .a_out(a_bus), .fab(fab), .fba(fba),
    .ovr_ab(ovr_ab), .ovr_ba(ovr_ba), .int_(int_)
  );

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_data[d] = '0;
      m_full[d] = 0;
      m_ovr[d]  = 0;
    end
  endtask

  // A word is accepted into an empty mailbox, replaces the old one when the
  // consumer reads at the same time, and is otherwise lost (overrun).
  task automatic model_edge();
    bit           ld, clr;
    logic [W-1:0] din;
    if (!rst_) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      ld  = (d == 0) ? ld_ab : ld_ba;
      clr = (d == 0) ? clr_fab : clr_fba;
      din = (d == 0) ? a_in : b_in;
      if (ld) begin
        if (!m_full[d] || clr) m_data[d] = din;
        if (m_full[d] && !clr) m_ovr[d] = 1;
        m_full[d] = 1;
      end else if (clr) begin
        m_full[d] = 0;
        m_ovr[d]  = 0;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    checks++;
    if ({b_bus, a_bus} !== {8'hFF, 8'h00}) begin
      errors++; $display("FAIL reset_tristate got b=%h a=%h exp b=ff a=00", b_bus, a_bus);
    end
    checks++;
    if ({fab, fba, ovr_ab, ovr_ba, int_} !== 5'b00001) begin
      errors++; $display("FAIL reset_flags got %b exp 00001", {fab, fba, ovr_ab, ovr_ba, int_});
    end
    oeb_ = 0;
    #1;
    checks++;
    if (b_bus !== 8'h00) begin
      errors++; $display("FAIL reset_enable got %h exp 00", b_bus);
    end
    @(negedge clk);
    rst_ = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_transfer();
    oeb_ = 0; ie_ab = 1; a_in = 8'hAA; ld_ab = 1;
    step();
    ld_ab = 0;
    checks++;
    if ({b_bus, fab, int_} !== {8'hAA, 1'b1, 1'b0}) begin
      errors++; $display("FAIL transfer_load got b=%h fab=%b int_=%b exp aa 1 0", b_bus, fab, int_);
    end
    oeb_ = 1;
    #1;
    checks++;
    if (b_bus !== 8'hFF) begin
      errors++; $display("FAIL transfer_disable got %h exp ff(released)", b_bus);
    end
    oeb_ = 0; clr_fab = 1;
    step();
    clr_fab = 0;
    checks++;
    if ({b_bus, fab, int_} !== {8'hAA, 1'b0, 1'b1}) begin
      errors++; $display("FAIL transfer_clear got b=%h fab=%b int_=%b exp aa 0 1", b_bus, fab, int_);
    end
  endtask

  task automatic test_overrun();
    a_in = 8'hF0; ld_ab = 1;
    step();
    a_in = 8'h0F;
    step();
    ld_ab = 0;
    checks++;
    if ({b_bus, fab, ovr_ab} !== {8'hF0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL overrun_set got b=%h fab=%b ovr=%b exp f0 1 1", b_bus, fab, ovr_ab);
    end
    clr_fab = 1;
    step();
    clr_fab = 0;
    checks++;
    if ({fab, ovr_ab} !== 2'b00) begin
      errors++; $display("FAIL overrun_clear got fab=%b ovr=%b exp 0 0", fab, ovr_ab);
    end
  endtask

  task automatic test_refill();
    a_in = 8'h55; ld_ab = 1;
    step();
    a_in = 8'hCC; clr_fab = 1;
    step();
    ld_ab = 0; clr_fab = 0;
    checks++;
    if ({b_bus, fab, ovr_ab} !== {8'hCC, 1'b1, 1'b0}) begin
      errors++; $display("FAIL refill got b=%h fab=%b ovr=%b exp cc 1 0", b_bus, fab, ovr_ab);
    end
    ld_ab = 1; a_in = 8'h33;
    step();
    a_in = 8'h44; clr_fab = 1;
    step();
    ld_ab = 0; clr_fab = 0;
    checks++;
    if ({b_bus, fab, ovr_ab} !== {8'h44, 1'b1, 1'b1}) begin
      errors++; $display("FAIL refill_keeps_ovr got b=%h fab=%b ovr=%b exp 44 1 1", b_bus, fab, ovr_ab);
    end
    clr_fab = 1;
    step();
    clr_fab = 0;
  endtask

  task automatic test_bidir();
    oea_ = 0; oeb_ = 0; ie_ab = 0; ie_ba = 1;
    a_in = 8'hFF; b_in = 8'h01; ld_ab = 1; ld_ba = 1;
    step();
    ld_ab = 0; ld_ba = 0;
    checks++;
    if ({b_bus, a_bus, fab, fba, int_} !== {8'hFF, 8'h01, 3'b110}) begin
      errors++; $display("FAIL bidir_load got b=%h a=%h fab=%b fba=%b int_=%b exp ff 01 1 1 0",
                         b_bus, a_bus, fab, fba, int_);
    end
    clr_fba = 1;
    step();
    clr_fba = 0;
    checks++;
    if ({fab, fba, int_} !== 3'b101) begin
      errors++; $display("FAIL bidir_clear got fab=%b fba=%b int_=%b exp 1 0 1", fab, fba, int_);
    end
    oea_ = 1;
    #1;
    checks++;
    if (a_bus !== 8'h00) begin
      errors++; $display("FAIL bidir_a_disable got %h exp 00(released)", a_bus);
    end
    oea_ = 0; clr_fab = 1;
    step();
    clr_fab = 0;
  endtask

  task automatic test_async_reset();
    oeb_ = 0; ie_ab = 1; a_in = 8'hAA; ld_ab = 1;
    step();
    a_in = 8'h11;
    step();
    ld_ab = 0;
    checks++;
    if ({b_bus, fab, ovr_ab} !== {8'hAA, 1'b1, 1'b1}) begin
      errors++; $display("FAIL async_setup got b=%h fab=%b ovr=%b exp aa 1 1", b_bus, fab, ovr_ab);
    end
    #2;
    rst_ = 0;
    #1;
    model_reset();
    checks++;
    if ({b_bus, fab, ovr_ab, int_} !== {8'h00, 3'b001}) begin
      errors++; $display("FAIL async_reset got b=%h fab=%b ovr=%b int_=%b exp 00 0 0 1",
                         b_bus, fab, ovr_ab, int_);
    end
    @(negedge clk);
    rst_ = 1;
  endtask

  task automatic test_random();
    logic [W+W+4:0] got, exp;
    for (int t = 0; t < 150; t++) begin
      a_in    = W'($urandom);
      b_in    = W'($urandom);
      ld_ab   = $urandom_range(0, 1) == 1;
      ld_ba   = $urandom_range(0, 1) == 1;
      clr_fab = $urandom_range(0, 2) == 0;
      clr_fba = $urandom_range(0, 2) == 0;
      oeb_    = $urandom_range(0, 3) == 0;
      oea_    = $urandom_range(0, 3) == 0;
      ie_ab   = $urandom_range(0, 1) == 1;
      ie_ba   = $urandom_range(0, 1) == 1;
      step();
      exp = {oeb_ ? 8'hFF : m_data[0], oea_ ? 8'h00 : m_data[1],
             m_full[0], m_full[1], m_ovr[0], m_ovr[1],
             ~((m_full[0] & ie_ab) | (m_full[1] & ie_ba))};
      got = {b_bus, a_bus, fab, fba, ovr_ab, ovr_ba, int_};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random[%0d] got %h exp %h", t, got, exp);
      end else begin
        $display("txn %0d ld=%b%b clr=%b%b b=%h a=%h flags=%b", t, ld_ab, ld_ba,
                 clr_fab, clr_fba, b_bus, a_bus, got[4:0]);
      end
    end
    ld_ab = 0; ld_ba = 0; clr_fab = 0; clr_fba = 0;
  endtask

  initial begin
    test_reset();
    test_transfer();
    test_overrun();
    test_refill();
    test_bidir();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
